// File: rtl/serial_add_arbiter.sv
// Bit-serial adder shared between two round-robin requesters.
// One full-adder cell and one carry flop walk the operands LSB-first over WIDTH cycles.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_prio;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_id;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;
    logic w_s;
    logic w_c;
    logic w_last;

    assign w_idle   = (r_state == S_IDLE);
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || !r_prio);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || r_prio);

    // Gated by rst_n so neither requester sees a grant while reset is held.
    assign req0_ready = w_grant0 & rst_n;
    assign req1_ready = w_grant1 & rst_n;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_prio    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_id      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_a     <= w_grant1 ? req1_a : req0_a;
                        r_b     <= w_grant1 ? req1_b : req0_b;
                        r_carry <= w_grant1 ? req1_cin : req0_cin;
                        r_cnt   <= '0;
                        r_id    <= w_grant1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_acc   <= {w_s, r_acc[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    // Response registers only update on completion so they hold between ops.
                    if (w_last) begin
                        rsp_sum   <= {w_s, r_acc[WIDTH-1:1]};
                        rsp_cout  <= w_c;
                        rsp_id    <= r_id;
                        rsp_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_prio    <= ~rsp_id;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
